// File: rtl/fnn_pkg.sv
// Shared types and helpers for the FNN accelerator datapath blocks.
package fnn_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    SHIFT   = 1'b1
  } ser_state_t;

  // Counter width that stays legal (>= 1 bit) when a layer has a single neuron.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_output_serializer.sv
// Gathers one layer's per-neuron outputs, then replays them as a gap-free serial
// burst (neuron 0 first) that feeds myinput/myinputValid of the next layer.
module layer_output_serializer
  import fnn_pkg::*;
#(
  parameter int numNeuron = 10,
  parameter int dataWidth = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeuron*dataWidth-1:0] in_data,
  input  logic [numNeuron-1:0]           in_valid,
  output logic [dataWidth-1:0]           out_data,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam int CW = cnt_w(numNeuron);
  localparam logic [CW-1:0] LAST = CW'(numNeuron - 1);

  // Handshake: in_valid[i] is a one-cycle strobe qualifying slice i of in_data;
  // out_valid has no ready, every cycle with out_valid=1 delivers one element.

  ser_state_t                 state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [numNeuron-1:0]       cap_mask_q, cap_mask_d;
  logic                       overrun_q, overrun_d;
  logic [dataWidth-1:0]       buf_q [numNeuron];
  logic [dataWidth-1:0]       buf_d [numNeuron];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      cap_mask_q <= '0;
      overrun_q  <= 1'b0;
      buf_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_mask_q <= cap_mask_d;
      overrun_q  <= overrun_d;
      buf_q      <= buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_mask_d = cap_mask_q;
    overrun_d  = overrun_q;
    buf_d      = buf_q;
    unique case (state_q)
      COLLECT: begin
        // Repeated strobes simply overwrite: the latest value of a neuron wins.
        for (int i = 0; i < numNeuron; i++) begin
          if (in_valid[i]) begin
            buf_d[i]      = in_data[i*dataWidth +: dataWidth];
            cap_mask_d[i] = 1'b1;
          end
        end
        if ((cap_mask_q | in_valid) == {numNeuron{1'b1}}) begin
          state_d    = SHIFT;
          cap_mask_d = '0;
          cnt_d      = '0;
        end
      end
      SHIFT: begin
        // Strobes here cannot be stored without corrupting the burst; flag them.
        if (in_valid != '0) overrun_d = 1'b1;
        if (cnt_q == LAST) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign busy      = (state_q == SHIFT);
  assign out_valid = busy;
  assign out_data  = busy ? buf_q[cnt_q] : '0;
  assign overrun   = overrun_q;

endmodule

// File: doc/layer_output_serializer.md
# layer_output_serializer

Collects the parallel outputs of one fully-connected layer's neurons, each arriving with its own `outvalid` pulse, into a capture buffer. Once every neuron of the layer has reported, it replays the values as a contiguous serial burst on `out_data`/`out_valid`. That burst drives the `myinput`/`myinputValid` pins of every neuron in the next layer. The block sits between layer L and layer L+1 of the FNN accelerator.

## Interface
- `numNeuron`, 10, neurons in the producing layer; equals `numWeight` of the consuming layer.
- `dataWidth`, 16, width of one neuron output / next-layer input.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: **synchronous, active-low** reset (0 = reset), sampled on the rising edge of `clk`.
- `in_data` in `numNeuron*dataWidth`: neuron outputs; neuron i occupies bits `[i*dataWidth +: dataWidth]`.
- `in_valid` in `numNeuron`: bit i is the `outvalid` of neuron i (single-cycle pulses).
- `out_data` out `dataWidth`: serial value to the next layer; 0 whenever `out_valid` = 0.
- `out_valid` out 1: high for exactly `numNeuron` consecutive cycles per burst.
- `busy` out 1: high while in SHIFT.
- `overrun` out 1: sticky error flag; cleared only by reset.

## Operation
- States are COLLECT and SHIFT. Reset enters COLLECT and clears `cap_mask`, `cnt`, the buffer and `overrun`.
- **COLLECT**
  - For each i with `in_valid[i]`=1, set `buf[i] <= in_data` slice i and `cap_mask[i] <= 1`.
  - A repeated pulse for an already-captured neuron overwrites `buf[i]`, last value wins, and is not an error.
  - Pulses from several or all neurons in the same cycle are all captured.
  - When `cap_mask | in_valid` is all ones at an edge, go to SHIFT at that same edge, with `cap_mask <= 0` and `cnt <= 0`.
- **SHIFT**
  - `out_valid` = 1 and `out_data` = `buf[cnt]`.
  - `cnt` increments every cycle.
  - At the edge where `cnt` = `numNeuron-1`, go to COLLECT with `cnt <= 0`.
  - There is no backpressure, because the consumer neurons have none. The burst is never stalled or gapped, since a gap would create a false falling edge of `myinputValid` in the consumer.
  - Any `in_valid` bit sampled in SHIFT is dropped, sets `overrun <= 1`, and does not touch `buf` or `cap_mask`.
- Data is passed bit-exact, with no arithmetic or saturation. Element order is neuron 0 first.
- `cnt` width is `$clog2(numNeuron)`. `cap_mask` width is `numNeuron`.
- `busy` = (state == SHIFT).

## Timing
- Outputs in reset and in COLLECT: `out_valid`=0, `out_data`=0, `busy`=0. `overrun`=0 after reset.
- `out_valid`, `out_data` and `busy` are decoded from registered state and `cnt` only, with no input-to-output combinational path.
- Latency: if the final missing `in_valid` is sampled at edge k, `out_valid` is high from edge k through edge k+`numNeuron`, and low after edge k+`numNeuron`.
- A new capture can be sampled at edge k+`numNeuron`+1 at the earliest.
  - A pulse at edge k+`numNeuron` is still in SHIFT, so it is dropped and sets `overrun`.
  - Consecutive bursts are therefore separated by at least one idle cycle.
- `numNeuron`=1: SHIFT lasts exactly one cycle.
- A reset asserted mid-SHIFT aborts the burst. `out_valid` drops after that edge, and captured data is discarded.

## Structure
- Put `typedef enum logic {COLLECT, SHIFT} ser_state_t` in the shared package `fnn_pkg`.
- No sub-module: a flat capture register array plus counter/FSM, roughly 120–160 lines.

## Test plan
All scenarios use `numNeuron`=10, `dataWidth`=16.
- **Simultaneous capture:** all 10 `in_valid` bits pulse at edge k with `in_data` slice i = 16'h0100+i -> `out_valid` high for 10 cycles; `out_data` = 0100, 0101, …, 0109; then low; `overrun`=0.
- **Staggered capture:** neurons pulse one per cycle in order 9 down to 0, with neuron 0's pulse at edge k -> the burst starts at edge k in neuron order 0..9; `out_valid` stays 0 until neuron 0's pulse arrives.
- **Duplicate pulse:** neuron 3 pulses 16'h1111 and then 16'h2222 before the set completes -> the burst carries 2222 in position 3, `overrun`=0.
- **Overrun:** during SHIFT, neuron 5 pulses 16'hDEAD -> `overrun` goes to 1 and stays there; the current burst is unchanged; `cap_mask` stays 0, so the next burst needs all 10 pulses anew.
- **Reset mid-burst:** `rst`=0 for one cycle at `cnt`=4 -> after that edge `out_valid`=0 and `out_data`=0. A subsequent full capture yields a clean 10-cycle burst of the new data only.
- **Back-to-back:** a second full capture is issued at edge k+11 -> two bursts separated by exactly one idle cycle; a scoreboard checks all 20 values.
